// File: rtl/dbg_pkg.sv
// Shared types and defaults for the board-side debug write unit.
package dbg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0]  FULL_BYTES      = 3'd4;
    localparam int unsigned DEF_DB_CYCLES   = 100000;
    localparam int unsigned DEF_ACK_TIMEOUT = 255;
    localparam int unsigned DEF_ADDR_W      = 8;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned TCNT_W          = 8;

endpackage

// File: rtl/dbg_write_unit_if.sv
// Held request/acknowledge write bus into the halted CPU's debug port.
interface dbg_wr_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              wr_req;
    logic              wr_mem;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              wr_ack;

    modport master (output wr_req, wr_mem, wr_addr, wr_data, input wr_ack);
    modport slave  (input wr_req, wr_mem, wr_addr, wr_data, output wr_ack);
endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-time filter and rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic [1:0]       r_sync;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;
    logic             w_differ;
    logic             w_flip;

    assign w_differ = (r_sync[1] != r_level);
    assign w_flip   = w_differ && (r_cnt == CNT_W'(DB_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_level <= 1'b0;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn};
            r_pulse <= w_flip && r_sync[1];
            if (w_flip) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign pulse = r_pulse;
endmodule

// File: rtl/dbg_write_unit.sv
// Debug writer: assembles a 32-bit word from switch bytes and writes it into the halted CPU.
module dbg_write_unit
    import dbg_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
    parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
    parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
    input  logic              clk5MHz,
    input  logic              rst,
    input  logic [7:0]        sw,
    input  logic              btn_load,
    input  logic              btn_addr,
    input  logic              btn_commit,
    input  logic              mem,
    input  logic              cpu_halted,
    dbg_wr_if.master          wr_bus,
    output logic [DATA_W-1:0] stage,
    output logic [2:0]        byte_cnt,
    output logic              busy,
    output logic              err
);
    state_t              r_state, w_state_n;
    logic [DATA_W-1:0]   r_stage, w_stage_n;
    logic [2:0]          r_byte_cnt, w_byte_cnt_n;
    logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_n;
    logic [DATA_W-1:0]   r_wr_data, w_wr_data_n;
    logic                r_wr_mem, w_wr_mem_n;
    logic                r_wr_req;
    logic                r_busy;
    logic                r_err, w_err_n;
    logic [TCNT_W-1:0]   r_tcnt, w_tcnt_n;
    logic                w_ev_load, w_ev_addr, w_ev_commit;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_load (
        .clk(clk5MHz), .rst(rst), .btn(btn_load), .pulse(w_ev_load)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_addr (
        .clk(clk5MHz), .rst(rst), .btn(btn_addr), .pulse(w_ev_addr)
    );
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_commit (
        .clk(clk5MHz), .rst(rst), .btn(btn_commit), .pulse(w_ev_commit)
    );

    // Next-state and datapath updates; events only count in IDLE, commit > addr > load.
    always_comb begin
        w_state_n    = r_state;
        w_stage_n    = r_stage;
        w_byte_cnt_n = r_byte_cnt;
        w_wr_addr_n  = r_wr_addr;
        w_wr_data_n  = r_wr_data;
        w_wr_mem_n   = r_wr_mem;
        w_err_n      = r_err;
        w_tcnt_n     = r_tcnt;
        case (r_state)
            IDLE: begin
                if (w_ev_commit) begin
                    if (cpu_halted && (r_byte_cnt == FULL_BYTES)) begin
                        w_wr_data_n = r_stage;
                        w_wr_mem_n  = mem;
                        w_tcnt_n    = '0;
                        w_err_n     = 1'b0;
                        w_state_n   = REQ;
                    end else begin
                        w_err_n = 1'b1;
                    end
                end else if (w_ev_addr) begin
                    w_wr_addr_n = ADDR_W'(sw);
                    w_err_n     = 1'b0;
                end else if (w_ev_load) begin
                    w_stage_n    = {r_stage[DATA_W-9:0], sw};
                    w_byte_cnt_n = (r_byte_cnt == FULL_BYTES) ? FULL_BYTES
                                                              : r_byte_cnt + 3'd1;
                    w_err_n      = 1'b0;
                end
            end
            REQ: begin
                w_tcnt_n = r_tcnt + TCNT_W'(1);
                if (wr_bus.wr_ack) begin
                    w_state_n = DONE;
                end else if (!cpu_halted || (r_tcnt == TCNT_W'(ACK_TIMEOUT - 1))) begin
                    w_err_n   = 1'b1;
                    w_state_n = IDLE;
                end
            end
            DONE: begin
                w_wr_addr_n  = r_wr_addr + ADDR_W'(1);
                w_byte_cnt_n = '0;
                w_state_n    = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk5MHz) begin
        if (rst) begin
            r_state    <= IDLE;
            r_stage    <= '0;
            r_byte_cnt <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_mem   <= 1'b0;
            r_wr_req   <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            r_state    <= w_state_n;
            r_stage    <= w_stage_n;
            r_byte_cnt <= w_byte_cnt_n;
            r_wr_addr  <= w_wr_addr_n;
            r_wr_data  <= w_wr_data_n;
            r_wr_mem   <= w_wr_mem_n;
            r_wr_req   <= (w_state_n == REQ);
            r_busy     <= (w_state_n != IDLE);
            r_err      <= w_err_n;
            r_tcnt     <= w_tcnt_n;
        end
    end

    assign wr_bus.wr_req  = r_wr_req;
    assign wr_bus.wr_mem  = r_wr_mem;
    assign wr_bus.wr_addr = r_wr_addr;
    assign wr_bus.wr_data = r_wr_data;
    assign stage          = r_stage;
    assign byte_cnt       = r_byte_cnt;
    assign busy           = r_busy;
    assign err            = r_err;
endmodule
